// File: rtl/z16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : z16_pkg
//  Description : Shared constants, fetch entry type and FSM states for the
//                z16 instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package z16_pkg;

    function automatic int instr_bytes(input int instr_w);
        return instr_w / 8;
    endfunction

    localparam int Z16_ADDR_W  = 16;
    localparam int Z16_INSTR_W = 16;
    localparam int INSTR_BYTES = instr_bytes(Z16_INSTR_W);

    typedef struct packed {
        logic [Z16_ADDR_W-1:0]  pc;
        logic [Z16_INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/z16_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : z16_fetch_fifo
//  Description : Synchronous prefetch FIFO with push, pop, flush and count.
//  Revision    : 1.0 - initial release
// ============================================================================
module z16_fetch_fifo #(
    parameter int  DATA_W  = 32,
    parameter int  DEPTH   = 4,
    localparam int C_CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [DATA_W-1:0]  i_data,
    output logic [DATA_W-1:0]  o_data,
    output logic [C_CNT_W-1:0] o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != C_CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/z16_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : z16_fetch_unit
//  Description : Instruction fetch with prefetch FIFO and redirect support.
//                Define Z16_FETCH_ALIGN_CHECK_EN to trap misaligned redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module z16_fetch_unit
    import z16_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                INSTR_W    = 16,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_instr,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_instr_pc,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    output logic               o_fault
);

    localparam int                c_BYTES      = instr_bytes(INSTR_W);
    localparam int                c_ENTRY_W    = ADDR_W + INSTR_W;
    localparam int                c_CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ADDR_W'(c_BYTES - 1);

    fetch_state_t        r_state;
    fetch_state_t        w_state_next;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [c_CNT_W-1:0]  w_count;
    logic [c_ENTRY_W-1:0] w_head;
    logic                w_run;
    logic                w_pop;
    logic                w_flush;

    // Outputs are gated by reset combinationally so nothing leaks while held in reset.
    assign w_run         = i_rst_n && (r_state == ST_RUN);
    assign o_instr_valid = w_run && (w_count != '0);
    assign w_pop         = o_instr_valid && i_instr_ready;
    assign w_flush       = w_run && i_redirect;
    assign o_imem_req    = w_run && !i_redirect &&
                           ((w_count != c_CNT_W'(FIFO_DEPTH)) || w_pop);
    assign o_imem_addr   = r_fetch_pc;
    assign o_instr       = o_instr_valid ? w_head[INSTR_W-1:0] : '0;
    assign o_instr_pc    = o_instr_valid ? w_head[c_ENTRY_W-1:INSTR_W] : '0;

    z16_fetch_fifo #(
        .DATA_W (c_ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (o_imem_req),
        .i_pop   (w_pop && !i_redirect),
        .i_flush (w_flush),
        .i_data  ({r_fetch_pc, i_imem_instr}),
        .o_data  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_flush) begin
            r_fetch_pc <= i_redirect_pc & ~c_ALIGN_MASK;
        end else if (o_imem_req) begin
            r_fetch_pc <= r_fetch_pc + ADDR_W'(c_BYTES);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_fault      = 1'b0;
`ifdef Z16_FETCH_ALIGN_CHECK_EN
        if ((r_state == ST_RUN) && w_flush && ((i_redirect_pc & c_ALIGN_MASK) != '0)) begin
            w_state_next = ST_FAULT;
        end
        o_fault = (r_state == ST_FAULT);
`endif
    end

endmodule
`default_nettype wire

// File: doc/z16_fetch_unit.md
Z16_FETCH_UNIT -- requirements
Module: z16_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 16, PC and memory address width.
REQ-002 Parameter INSTR_W, default 16, instruction width; multiple of 8.
REQ-003 Parameter FIFO_DEPTH, default 4, prefetch entries; power of two, >=2.
REQ-004 Parameter RESET_PC, default 0, PC loaded at reset.
REQ-005 i_clk  in  1  single clock; all state on rising edge.
REQ-006 i_rst_n  in  1  synchronous active-low reset.
REQ-007 o_imem_req  out  1  fetch request this cycle.
REQ-008 o_imem_addr  out  ADDR_W  fetch address (current fetch PC).
REQ-009 i_imem_instr  in  INSTR_W  instruction at o_imem_addr, combinational, same cycle.
REQ-010 o_instr_valid  out  1  head FIFO entry available.
REQ-011 i_instr_ready  in  1  consumer accepts head entry.
REQ-012 o_instr  out  INSTR_W  head instruction.
REQ-013 o_instr_pc  out  ADDR_W  address of head instruction.
REQ-014 i_redirect  in  1  branch/jump: flush and restart fetch.
REQ-015 i_redirect_pc  in  ADDR_W  redirect target.
REQ-016 o_fault  out  1  sticky misalignment fault (0 when macro absent).

Function
REQ-017 State machine states RUN and FAULT; reset enters RUN; FAULT only reachable with macro.
REQ-018 In RUN, o_imem_req=1 iff i_redirect=0 and (count<FIFO_DEPTH or pop this cycle).
REQ-019 On o_imem_req, push {fetch_pc, i_imem_instr} and fetch_pc <= fetch_pc + INSTR_W/8, wrapping modulo 2^ADDR_W.
REQ-020 o_instr_valid = (count!=0); pop occurs when o_instr_valid & i_instr_ready.
REQ-021 Simultaneous push and pop when full or partially full: count unchanged, order preserved.
REQ-022 Pop when empty impossible; push when full without pop suppressed by REQ-018.
REQ-023 Latency: instruction requested in cycle N is on o_instr at N+1 if FIFO empty at N.
REQ-024 i_redirect=1: next edge clears FIFO (count=0), sets fetch_pc=i_redirect_pc; no push, pop ignored; o_instr_valid low the following cycle.
REQ-025 i_redirect takes priority over push and pop in the same cycle.
REQ-026 o_instr/o_instr_pc hold stable while o_instr_valid=1 and i_instr_ready=0.
REQ-027 In FAULT: o_imem_req=0, o_instr_valid=0, o_fault=1, redirects ignored, until reset.

Reset
REQ-028 i_rst_n=0 at edge: fetch_pc=RESET_PC, count=0, state=RUN, o_fault=0.
REQ-029 While i_rst_n=0: o_imem_req=0, o_instr_valid=0; o_instr, o_instr_pc=0.
REQ-030 Reset mid-operation discards all FIFO contents and any pending redirect.

Configuration
REQ-031 Macro Z16_FETCH_ALIGN_CHECK_EN defined: redirect with i_redirect_pc not multiple of INSTR_W/8 flushes FIFO and enters FAULT.
REQ-032 Macro undefined: low log2(INSTR_W/8) bits of i_redirect_pc forced to zero; o_fault tied 0; FAULT state absent.

Structure
REQ-033 Package z16_pkg holds INSTR_BYTES helper constant, fetch entry typedef {pc, instr}, and state enum.
REQ-034 Sub-module z16_fetch_fifo (parametrised synchronous FIFO, push/pop/flush, count) holds the prefetch buffer.

Verification
REQ-035 Reset, ready=1, mem returns addr: o_instr_pc sequence 0x0000,0x0002,0x0004 from cycle 2, valid continuous.
REQ-036 Ready=0 for 10 cycles: exactly 4 pushes, o_imem_req low after, head stays pc 0x0000; ready=1 then drains in order.
REQ-037 Redirect to 0x0100 with 3 entries buffered: next cycle valid=0, cycle after o_instr_pc=0x0100.
REQ-038 fetch_pc=0xFFFE: next fetched pc 0x0000 (wrap).
REQ-039 Redirect to 0x0101: macro on -> o_fault=1, req=0 until reset; macro off -> fetch from 0x0100.
REQ-040 i_rst_n=0 for one cycle while full: FIFO empty, fetch restarts at RESET_PC.
